fetch_ctrl: RTL and testbench

- Front-end sequencer for the IITB-RISC-23 pipeline. Drives the fetch stage's PC write-enable and redirect inputs, and the IF/ID capture enable.
- Produces per-stage flush controls.
- Arbitrates redirect sources (WB R0-write, EX branch/JLR, ID jump).
- Freezes fetch while an LM/SM instruction in ID is expanded into one micro-op per set mask bit.

---
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Front-end sequencer: PC/IF-ID enables, per-stage flushes, redirect arbitration
// and LM/SM micro-op expansion for the IITB-RISC-23 pipeline.
module fetch_ctrl #(
    parameter int PC_W  = 16,
    parameter int NREG  = 8,
    parameter int IDX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_use_i,
    input  logic              id_is_lmsm_i,
    input  logic [NREG-1:0]   id_lmsm_mask_i,
    input  logic              id_jump_i,
    input  logic [PC_W-1:0]   id_jump_pc_i,
    input  logic              ex_redirect_i,
    input  logic [PC_W-1:0]   ex_redirect_pc_i,
    input  logic              wb_redirect_i,
    input  logic [PC_W-1:0]   wb_redirect_pc_i,
    output logic              pc_we_o,
    output logic              redirect_en_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic              ifid_we_o,
    output logic [3:0]        flush_o,
    output logic              lmsm_active_o,
    output logic [IDX_W-1:0]  lmsm_idx_o,
    output logic              lmsm_last_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        MULTI = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREG-1:0]   r_mask;
    logic [NREG-1:0]   w_mask_nxt;
    logic [NREG-1:0]   w_mask_clr;
    logic [IDX_W-1:0]  w_idx;
    logic              w_found;
    logic              w_one;

    // Lowest set bit of the remaining mask selects the current micro-op.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (r_mask[i] && !w_found) begin
                w_idx   = IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_mask_clr = r_mask & (r_mask - NREG'(1));
    assign w_one      = (r_mask != '0) && (w_mask_clr == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        pc_we_o       = 1'b0;
        redirect_en_o = 1'b0;
        redirect_pc_o = '0;
        ifid_we_o     = 1'b0;
        flush_o       = '0;
        lmsm_active_o = 1'b0;
        lmsm_idx_o    = '0;
        lmsm_last_o   = 1'b0;

        if (r_state == BOOT) begin
            flush_o     = '1;
            w_state_nxt = RUN;
        end else if (wb_redirect_i) begin
            redirect_en_o = 1'b1;
            redirect_pc_o = wb_redirect_pc_i;
            pc_we_o       = 1'b1;
            ifid_we_o     = 1'b1;
            flush_o       = 4'b1111;
            w_mask_nxt    = '0;
            w_state_nxt   = RUN;
        end else if (ex_redirect_i) begin
            redirect_en_o = 1'b1;
            redirect_pc_o = ex_redirect_pc_i;
            pc_we_o       = 1'b1;
            ifid_we_o     = 1'b1;
            flush_o       = 4'b0011;
            w_mask_nxt    = '0;
            w_state_nxt   = RUN;
        end else if (r_state == MULTI) begin
            lmsm_active_o = 1'b1;
            lmsm_idx_o    = w_idx;
            lmsm_last_o   = w_one;
            if (load_use_i) begin
                lmsm_active_o = 1'b0;
                flush_o       = 4'b0010;
            end else begin
                w_mask_nxt = w_mask_clr;
                if (w_one) begin
                    pc_we_o     = 1'b1;
                    ifid_we_o   = 1'b1;
                    w_state_nxt = RUN;
                end
            end
        end else if (id_jump_i) begin
            redirect_en_o = 1'b1;
            redirect_pc_o = id_jump_pc_i;
            pc_we_o       = 1'b1;
            ifid_we_o     = 1'b1;
            flush_o       = 4'b0001;
        end else if (load_use_i) begin
            flush_o = 4'b0010;
        end else if (id_is_lmsm_i && (id_lmsm_mask_i != '0)) begin
            w_mask_nxt  = id_lmsm_mask_i;
            w_state_nxt = MULTI;
        end else begin
            pc_we_o   = 1'b1;
            ifid_we_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random traffic,
// compared each cycle against a queue-based model of the micro-op list.
module tb_fetch_ctrl;

    localparam int PC_W  = 16;
    localparam int NREG  = 8;
    localparam int IDX_W = 3;

    logic              clk;
    logic              rst_n;
    logic              load_use_i;
    logic              id_is_lmsm_i;
    logic [NREG-1:0]   id_lmsm_mask_i;
    logic              id_jump_i;
    logic [PC_W-1:0]   id_jump_pc_i;
    logic              ex_redirect_i;
    logic [PC_W-1:0]   ex_redirect_pc_i;
    logic              wb_redirect_i;
    logic [PC_W-1:0]   wb_redirect_pc_i;
    logic              pc_we_o;
    logic              redirect_en_o;
    logic [PC_W-1:0]   redirect_pc_o;
    logic              ifid_we_o;
    logic [3:0]        flush_o;
    logic              lmsm_active_o;
    logic [IDX_W-1:0]  lmsm_idx_o;
    logic              lmsm_last_o;

    fetch_ctrl #(.PC_W(PC_W), .NREG(NREG), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_use_i       (load_use_i),
        .id_is_lmsm_i     (id_is_lmsm_i),
        .id_lmsm_mask_i   (id_lmsm_mask_i),
        .id_jump_i        (id_jump_i),
        .id_jump_pc_i     (id_jump_pc_i),
        .ex_redirect_i    (ex_redirect_i),
        .ex_redirect_pc_i (ex_redirect_pc_i),
        .wb_redirect_i    (wb_redirect_i),
        .wb_redirect_pc_i (wb_redirect_pc_i),
        .pc_we_o          (pc_we_o),
        .redirect_en_o    (redirect_en_o),
        .redirect_pc_o    (redirect_pc_o),
        .ifid_we_o        (ifid_we_o),
        .flush_o          (flush_o),
        .lmsm_active_o    (lmsm_active_o),
        .lmsm_idx_o       (lmsm_idx_o),
        .lmsm_last_o      (lmsm_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: booted flag plus the list of register indices still to issue.
    bit m_booted;
    int m_pend[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic eval_cycle();
        logic        e_pc, e_re, e_if, e_act, e_last;
        logic [15:0] e_rpc;
        logic [3:0]  e_fl;
        int          e_idx;
        bit          idx_chk;
        e_pc = 0; e_re = 0; e_if = 0; e_act = 0; e_last = 0;
        e_rpc = '0; e_fl = 4'h0; e_idx = 0; idx_chk = 1;
        if (!rst_n) begin
            e_fl = 4'hF;
            m_booted = 0;
            m_pend.delete();
        end else if (!m_booted) begin
            e_fl = 4'hF;
            m_booted = 1;
        end else if (wb_redirect_i || ex_redirect_i) begin
            e_re = 1; e_pc = 1; e_if = 1;
            e_rpc = wb_redirect_i ? wb_redirect_pc_i : ex_redirect_pc_i;
            e_fl  = wb_redirect_i ? 4'b1111 : 4'b0011;
            if (m_pend.size() != 0) idx_chk = 0;
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            e_idx  = m_pend[0];
            e_last = (m_pend.size() == 1);
            if (load_use_i) begin
                e_fl = 4'b0010;
            end else begin
                e_act = 1;
                void'(m_pend.pop_front());
                if (m_pend.size() == 0) begin
                    e_pc = 1; e_if = 1;
                end
            end
        end else if (id_jump_i) begin
            e_re = 1; e_pc = 1; e_if = 1; e_rpc = id_jump_pc_i; e_fl = 4'b0001;
        end else if (load_use_i) begin
            e_fl = 4'b0010;
        end else if (id_is_lmsm_i && id_lmsm_mask_i != 0) begin
            for (int i = 0; i < NREG; i++)
                if (id_lmsm_mask_i[i]) m_pend.push_back(i);
        end else begin
            e_pc = 1; e_if = 1;
        end
        chk("pc_we", 32'(pc_we_o), 32'(e_pc));
        chk("redirect_en", 32'(redirect_en_o), 32'(e_re));
        chk("redirect_pc", 32'(redirect_pc_o), 32'(e_rpc));
        chk("ifid_we", 32'(ifid_we_o), 32'(e_if));
        chk("flush", 32'(flush_o), 32'(e_fl));
        chk("lmsm_active", 32'(lmsm_active_o), 32'(e_act));
        if (idx_chk) begin
            chk("lmsm_idx", 32'(lmsm_idx_o), 32'(e_idx));
            chk("lmsm_last", 32'(lmsm_last_o), 32'(e_last));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        load_use_i = 0; id_is_lmsm_i = 0; id_lmsm_mask_i = '0;
        id_jump_i = 0; id_jump_pc_i = '0;
        ex_redirect_i = 0; ex_redirect_pc_i = '0;
        wb_redirect_i = 0; wb_redirect_pc_i = '0;
    endtask

    initial begin
        rst_n = 0;
        clr();
        m_booted = 0;
        @(posedge clk);
        #1;
        repeat (2) cyc();
        rst_n = 1;
        repeat (4) cyc();

        id_jump_i = 1; id_jump_pc_i = 16'h0040;
        ex_redirect_i = 1; ex_redirect_pc_i = 16'h0100;
        cyc();
        clr(); cyc();

        load_use_i = 1; cyc();
        clr(); cyc();

        id_is_lmsm_i = 1; id_lmsm_mask_i = 8'b1010_0101;
        repeat (5) cyc();
        clr(); repeat (2) cyc();

        id_is_lmsm_i = 1; id_lmsm_mask_i = 8'hFF;
        repeat (4) cyc();
        load_use_i = 1; cyc();
        load_use_i = 0; repeat (2) cyc();
        wb_redirect_i = 1; wb_redirect_pc_i = 16'h0200; cyc();
        clr(); repeat (2) cyc();

        id_is_lmsm_i = 1; id_lmsm_mask_i = 8'h00; repeat (2) cyc();
        clr(); cyc();

        id_is_lmsm_i = 1; id_lmsm_mask_i = 8'h3C; repeat (2) cyc();
        ex_redirect_i = 1; ex_redirect_pc_i = 16'h0ABC; cyc();
        clr();
        id_is_lmsm_i = 1; id_lmsm_mask_i = 8'h3C; repeat (2) cyc();
        rst_n = 0;
        #1;
        eval_cycle();
        clr(); cyc();
        rst_n = 1;
        repeat (3) cyc();

        for (int n = 0; n < 600; n++) begin
            load_use_i       = ($urandom_range(0, 5) == 0);
            id_is_lmsm_i     = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       id_lmsm_mask_i = 8'h00;
                1:       id_lmsm_mask_i = 8'hFF;
                default: id_lmsm_mask_i = NREG'($urandom);
            endcase
            id_jump_i        = ($urandom_range(0, 7) == 0);
            id_jump_pc_i     = PC_W'($urandom);
            ex_redirect_i    = ($urandom_range(0, 11) == 0);
            ex_redirect_pc_i = PC_W'($urandom);
            wb_redirect_i    = ($urandom_range(0, 19) == 0);
            wb_redirect_pc_i = PC_W'($urandom);
            if (n == 300) begin
                rst_n = 0;
                #1;
                eval_cycle();
                cyc();
                rst_n = 1;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
